// File: rtl/round_referee_if.sv
// Signal bundle between the game logic and the round referee.
// master drives the game inputs; slave is the referee side.
interface round_referee_if;
    logic [2:0] Game_State;
    logic       frame_tick;
    logic       Blue_Hit;
    logic       Red_Hit;
    logic       Reset_Round;
    logic       Blue_W;
    logic       Red_W;
    logic       Crash_Active;
    logic [1:0] Round_Winner;
    logic [3:0] Blue_Score;
    logic [3:0] Red_Score;

    modport master (
        output Game_State, frame_tick, Blue_Hit, Red_Hit,
        input  Reset_Round, Blue_W, Red_W, Crash_Active,
        input  Round_Winner, Blue_Score, Red_Score
    );

    modport slave (
        input  Game_State, frame_tick, Blue_Hit, Red_Hit,
        output Reset_Round, Blue_W, Red_W, Crash_Active,
        output Round_Winner, Blue_Score, Red_Score
    );
endinterface

// File: rtl/round_referee.sv
// Match referee: latches collisions during a round, holds the crash display,
// scores the round and raises round-reset or match-win to the game FSM.
module round_referee #(
    parameter int WIN_SCORE    = 3,
    parameter int CRASH_FRAMES = 60
) (
    input  logic            Clk,
    input  logic            Reset_Game,
    round_referee_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        CRASH_WAIT,
        ISSUE
    } state_t;

    localparam logic [2:0] GS_MENU    = 3'd0;
    localparam logic [2:0] GS_STARTED = 3'd2;
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [7:0] FRAMES     = 8'(CRASH_FRAMES);
    localparam logic [1:0] RW_BLUE    = 2'b01;
    localparam logic [1:0] RW_RED     = 2'b10;

    state_t     state, state_next;
    logic       bh, bh_next;
    logic       rh, rh_next;
    logic [7:0] count, count_next;
    logic [1:0] verdict, verdict_next;
    logic       reset_round, reset_round_next;
    logic       blue_w, blue_w_next;
    logic       red_w, red_w_next;
    logic       crash_active, crash_active_next;
    logic [1:0] round_winner, round_winner_next;
    logic [3:0] blue_score, blue_score_next;
    logic [3:0] red_score, red_score_next;

    logic       hit_b, hit_r;
    logic       running;
    logic       issue_now;
    logic [3:0] blue_post, red_post;

    always_ff @(posedge Clk) begin
        if (Reset_Game) begin
            state        <= IDLE;
            bh           <= 1'b0;
            rh           <= 1'b0;
            count        <= 8'd0;
            verdict      <= 2'b00;
            reset_round  <= 1'b0;
            blue_w       <= 1'b0;
            red_w        <= 1'b0;
            crash_active <= 1'b0;
            round_winner <= 2'b00;
            blue_score   <= 4'd0;
            red_score    <= 4'd0;
        end else begin
            state        <= state_next;
            bh           <= bh_next;
            rh           <= rh_next;
            count        <= count_next;
            verdict      <= verdict_next;
            reset_round  <= reset_round_next;
            blue_w       <= blue_w_next;
            red_w        <= red_w_next;
            crash_active <= crash_active_next;
            round_winner <= round_winner_next;
            blue_score   <= blue_score_next;
            red_score    <= red_score_next;
        end
    end

    always_comb begin
        state_next        = state;
        bh_next           = bh;
        rh_next           = rh;
        count_next        = count;
        verdict_next      = verdict;
        reset_round_next  = reset_round;
        blue_w_next       = blue_w;
        red_w_next        = red_w;
        crash_active_next = crash_active;
        round_winner_next = round_winner;
        blue_score_next   = blue_score;
        red_score_next    = red_score;

        hit_b     = bh | bus.Blue_Hit;
        hit_r     = rh | bus.Red_Hit;
        running   = (bus.Game_State == GS_STARTED);
        issue_now = (count == 8'd0) || (bus.frame_tick && count == 8'd1);

        // Scores saturate at WIN so a restarted round can never overflow them.
        blue_post = blue_score;
        red_post  = red_score;
        if (verdict == RW_BLUE && blue_score < WIN)
            blue_post = blue_score + 4'd1;
        if (verdict == RW_RED && red_score < WIN)
            red_post = red_score + 4'd1;

        case (state)
            IDLE: begin
                reset_round_next  = 1'b0;
                blue_w_next       = 1'b0;
                red_w_next        = 1'b0;
                crash_active_next = 1'b0;
                if (bus.Game_State == GS_MENU) begin
                    blue_score_next   = 4'd0;
                    red_score_next    = 4'd0;
                    round_winner_next = 2'b00;
                end
                if (running) begin
                    state_next = PLAY;
                    bh_next    = 1'b0;
                    rh_next    = 1'b0;
                end
            end

            PLAY: begin
                if (!running) begin
                    state_next = IDLE;
                    bh_next    = 1'b0;
                    rh_next    = 1'b0;
                end else if (bus.frame_tick) begin
                    bh_next = 1'b0;
                    rh_next = 1'b0;
                    // A bike that crashed loses, so the verdict bits read {red won, blue won}.
                    if (hit_b || hit_r) begin
                        verdict_next      = {hit_b, hit_r};
                        count_next        = FRAMES;
                        crash_active_next = 1'b1;
                        state_next        = CRASH_WAIT;
                    end
                end else begin
                    bh_next = hit_b;
                    rh_next = hit_r;
                end
            end

            CRASH_WAIT: begin
                if (!running) begin
                    state_next        = IDLE;
                    crash_active_next = 1'b0;
                end else if (issue_now) begin
                    state_next        = ISSUE;
                    count_next        = 8'd0;
                    crash_active_next = 1'b0;
                    round_winner_next = verdict;
                    blue_score_next   = blue_post;
                    red_score_next    = red_post;
                    if (blue_post == WIN)
                        blue_w_next = 1'b1;
                    else if (red_post == WIN)
                        red_w_next = 1'b1;
                    else
                        reset_round_next = 1'b1;
                end else if (bus.frame_tick) begin
                    count_next = count - 8'd1;
                end
            end

            ISSUE: begin
                if (!running) begin
                    state_next       = IDLE;
                    reset_round_next = 1'b0;
                    blue_w_next      = 1'b0;
                    red_w_next       = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.Reset_Round  = reset_round;
    assign bus.Blue_W       = blue_w;
    assign bus.Red_W        = red_w;
    assign bus.Crash_Active = crash_active;
    assign bus.Round_Winner = round_winner;
    assign bus.Blue_Score   = blue_score;
    assign bus.Red_Score    = red_score;

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee: one instance with a 2-frame crash hold,
// one with a zero-frame hold, both with a three-round match.
module tb_round_referee;

    logic Clk;
    logic Reset_Game;
    int   vectors;
    int   miscompares;

    round_referee_if ifa();
    round_referee_if ifb();

    round_referee #(.WIN_SCORE(3), .CRASH_FRAMES(2)) dut_a (
        .Clk        (Clk),
        .Reset_Game (Reset_Game),
        .bus        (ifa.slave)
    );

    round_referee #(.WIN_SCORE(3), .CRASH_FRAMES(0)) dut_b (
        .Clk        (Clk),
        .Reset_Game (Reset_Game),
        .bus        (ifb.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [13:0] obsA();
        return {ifa.Reset_Round, ifa.Blue_W, ifa.Red_W, ifa.Crash_Active,
                ifa.Round_Winner, ifa.Blue_Score, ifa.Red_Score};
    endfunction

    function automatic logic [13:0] obsB();
        return {ifb.Reset_Round, ifb.Blue_W, ifb.Red_W, ifb.Crash_Active,
                ifb.Round_Winner, ifb.Blue_Score, ifb.Red_Score};
    endfunction

    // Drive one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic applyStimulus(input bit to_b, input logic [2:0] gs, input logic tick,
                                 input logic bhit, input logic rhit);
        ifa.Game_State = to_b ? 3'd0 : gs;
        ifa.frame_tick = to_b ? 1'b0 : tick;
        ifa.Blue_Hit   = to_b ? 1'b0 : bhit;
        ifa.Red_Hit    = to_b ? 1'b0 : rhit;
        ifb.Game_State = to_b ? gs : 3'd0;
        ifb.frame_tick = to_b ? tick : 1'b0;
        ifb.Blue_Hit   = to_b ? bhit : 1'b0;
        ifb.Red_Hit    = to_b ? rhit : 1'b0;
        @(negedge Clk);
    endtask

    task automatic checkOutput(input string tag, input logic [13:0] observed,
                               input logic rr, input logic bw, input logic rw,
                               input logic ca, input logic [1:0] win,
                               input logic [3:0] bs, input logic [3:0] rs);
        logic [13:0] expected;
        expected = {rr, bw, rw, ca, win, bs, rs};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b (rr bw rw ca win bs rs)",
                   tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset_Game  = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_a", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        checkOutput("reset_b", obsB(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        Reset_Game = 1'b0;

        // Red crashes: blue takes the round after a 2-frame crash hold.
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("red_play", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
        checkOutput("red_latched", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("red_crash", obsA(), 0, 0, 0, 1, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("red_hold", obsA(), 0, 0, 0, 1, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("red_frame1", obsA(), 0, 0, 0, 1, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("red_verdict", obsA(), 1, 0, 0, 0, 2'b01, 4'd1, 4'd0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("red_flag_held", obsA(), 1, 0, 0, 0, 2'b01, 4'd1, 4'd0);
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("red_paused", obsA(), 0, 0, 0, 0, 2'b01, 4'd1, 4'd0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("red_menu", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);

        // Draw: both bikes hit in separate cycles of the same frame.
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("draw_crash", obsA(), 0, 0, 0, 1, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("draw_verdict", obsA(), 1, 0, 0, 0, 2'b11, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("draw_paused", obsA(), 0, 0, 0, 0, 2'b11, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("paused_hit_ignored", obsA(), 0, 0, 0, 0, 2'b11, 4'd0, 4'd0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("draw_menu", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);

        // Two full matches: m=0 red keeps crashing (blue wins), m=1 blue keeps crashing.
        for (int m = 0; m < 2; m++) begin
            for (int k = 1; k <= 3; k++) begin
                logic [3:0] ks;
                logic [3:0] kprev;
                logic [1:0] wcode;
                ks    = 4'(k);
                kprev = 4'(k - 1);
                wcode = (m == 0) ? 2'b01 : 2'b10;
                applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
                applyStimulus(1'b0, 3'd2, 1'b1, logic'(m == 1), logic'(m == 0));
                checkOutput("match_same_cycle_hit", obsA(), 0, 0, 0, 1,
                            (k == 1) ? 2'b00 : wcode,
                            (m == 0) ? kprev : 4'd0, (m == 1) ? kprev : 4'd0);
                applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
                applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
                checkOutput("match_verdict", obsA(), logic'(k < 3),
                            logic'(k == 3 && m == 0), logic'(k == 3 && m == 1), 0, wcode,
                            (m == 0) ? ks : 4'd0, (m == 1) ? ks : 4'd0);
                applyStimulus(1'b0, (k < 3) ? 3'd1 : ((m == 0) ? 3'd3 : 3'd4),
                              1'b0, 1'b0, 1'b0);
                checkOutput("match_exit", obsA(), 0, 0, 0, 0, wcode,
                            (m == 0) ? ks : 4'd0, (m == 1) ? ks : 4'd0);
            end
            applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            checkOutput("match_menu_clear", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        end

        // A blue hit during the crash hold must not alter the latched verdict.
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("crash_hit_ignored", obsA(), 1, 0, 0, 0, 2'b01, 4'd1, 4'd0);
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);

        // Abort during the crash hold: back to idle with scores untouched.
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        checkOutput("abort_crash", obsA(), 0, 0, 0, 1, 2'b01, 4'd1, 4'd0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_idle", obsA(), 0, 0, 0, 0, 2'b01, 4'd1, 4'd0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_menu", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);

        // Reset while a flag is held in ISSUE.
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("issue_red_round", obsA(), 1, 0, 0, 0, 2'b10, 4'd0, 4'd1);
        Reset_Game = 1'b1;
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("issue_reset", obsA(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        Reset_Game = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Zero-frame crash hold: verdict two cycles after the detecting tick.
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("zero_play", obsB(), 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        checkOutput("zero_crash", obsB(), 0, 0, 0, 1, 2'b00, 4'd0, 4'd0);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("zero_verdict", obsB(), 1, 0, 0, 0, 2'b01, 4'd1, 4'd0);
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("zero_paused", obsB(), 0, 0, 0, 0, 2'b01, 4'd1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
